// File: rtl/alu_exec_stage.sv
// Execute-stage wrapper in front of a combinational ALU: operand register (O),
// result register (R) and an architectural carry flag for chained multi-word ops.
module alu_exec_stage #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FUNC_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    input  logic [FUNC_WIDTH-1:0] in_f,
    input  logic                  in_use_carry,
    input  logic                  clr_carry,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic                  alu_ci,
    output logic [FUNC_WIDTH-1:0] alu_f,
    input  logic [WIDTH-1:0]      alu_s,
    input  logic                  alu_co,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_s,
    output logic                  out_co,
    output logic                  carry_flag
);

    logic o_valid;
    logic o_use_carry;
    logic o_adv;

    // O hands its packet to the ALU/R when R is empty or being drained this cycle.
    assign o_adv    = o_valid & (~out_valid | out_ready);
    assign in_ready = ~o_valid | o_adv;
    assign alu_ci   = o_use_carry & carry_flag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid     <= 1'b0;
            o_use_carry <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_f       <= '0;
            out_valid   <= 1'b0;
            out_s       <= '0;
            out_co      <= 1'b0;
            carry_flag  <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                alu_a       <= in_a;
                alu_b       <= in_b;
                alu_f       <= in_f;
                o_use_carry <= in_use_carry;
                o_valid     <= 1'b1;
            end else if (o_adv) begin
                o_valid <= 1'b0;
            end

            if (o_adv) begin
                out_s     <= alu_s;
                out_co    <= alu_co;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // An explicit clear wins over the carry produced by an advancing op.
            if (clr_carry) begin
                carry_flag <= 1'b0;
            end else if (o_adv) begin
                carry_flag <= alu_co;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with an adder ALU stub and a queue-based
// reference model checked every cycle, plus hand-computed literal expectations.
module tb_alu_exec_stage;

    localparam int unsigned W  = 32;
    localparam int unsigned FW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [FW-1:0] in_f;
    logic          in_use_carry;
    logic          clr_carry;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic          alu_ci;
    logic [FW-1:0] alu_f;
    logic [W-1:0]  alu_s;
    logic          alu_co;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_s;
    logic          out_co;
    logic          carry_flag;

    alu_exec_stage #(.WIDTH(W), .FUNC_WIDTH(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_f(in_f), .in_use_carry(in_use_carry),
        .clr_carry(clr_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci), .alu_f(alu_f),
        .alu_s(alu_s), .alu_co(alu_co),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_co(out_co), .carry_flag(carry_flag)
    );

    always #5 clk = ~clk;

    // Behavioural ALU stub: plain add with carry in/out.
    logic [W:0] stub_sum;
    assign stub_sum = {1'b0, alu_a} + {1'b0, alu_b} + (W+1)'(alu_ci);
    assign alu_s    = stub_sum[W-1:0];
    assign alu_co   = stub_sum[W];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: packets waiting for the ALU, results waiting downstream.
    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [FW-1:0] f;
        logic          uc;
    } pkt_t;

    pkt_t          o_q[$];
    logic [W:0]    r_q[$];
    logic          m_carry = 1'b0;
    logic [W-1:0]  m_a = '0;
    logic [W-1:0]  m_b = '0;
    logic [FW-1:0] m_f = '0;
    logic          m_uc = 1'b0;
    bit            m_init = 1'b0;
    logic [W:0]    dut_log[$];

    always @(posedge clk) begin
        pkt_t       p;
        pkt_t       np;
        logic [W:0] res;
        bit         adv;
        bit         acc;
        if (!rst_n) begin
            o_q.delete();
            r_q.delete();
            m_carry = 1'b0;
            m_a = '0; m_b = '0; m_f = '0; m_uc = 1'b0;
            m_init = 1'b1;
        end else if (m_init) begin
            adv = (o_q.size() != 0) && ((r_q.size() == 0) || out_ready);
            acc = in_valid && ((o_q.size() == 0) || adv);
            res = '0;
            if (adv) begin
                p   = o_q.pop_front();
                res = (W+1)'(p.a) + (W+1)'(p.b) + (W+1)'(p.uc & m_carry);
                if (r_q.size() != 0) void'(r_q.pop_front());
                r_q.push_back(res);
            end else if (out_ready && r_q.size() != 0) begin
                void'(r_q.pop_front());
            end
            if (clr_carry) m_carry = 1'b0;
            else if (adv) m_carry = res[W];
            if (acc) begin
                np.a = in_a; np.b = in_b; np.f = in_f; np.uc = in_use_carry;
                o_q.push_back(np);
                m_a = in_a; m_b = in_b; m_f = in_f; m_uc = in_use_carry;
            end
        end
    end

    // Per-cycle compare against the model, sampled mid-low-phase.
    always @(negedge clk) begin
        #2;
        if (m_init) begin
            chk("in_ready", 64'(in_ready),
                64'((o_q.size() == 0) || (r_q.size() == 0) || out_ready));
            chk("out_valid", 64'(out_valid), 64'(r_q.size() != 0));
            chk("carry_flag", 64'(carry_flag), 64'(m_carry));
            chk("alu_a", 64'(alu_a), 64'(m_a));
            chk("alu_b", 64'(alu_b), 64'(m_b));
            chk("alu_f", 64'(alu_f), 64'(m_f));
            chk("alu_ci", 64'(alu_ci), 64'(m_uc & m_carry));
            if (r_q.size() != 0) chk("out_result", 64'({out_co, out_s}), 64'(r_q[0]));
            if (rst_n && out_valid && out_ready) dut_log.push_back({out_co, out_s});
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [FW-1:0] f, input logic uc);
        bit done;
        done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_f = f; in_use_carry = uc;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        int base;
        rst_n = 1'b0; in_valid = 1'b1; in_a = 32'h7; in_b = 32'h9; in_f = 5'h3;
        in_use_carry = 1'b1; clr_carry = 1'b0; out_ready = 1'b1;

        // Reset with in_valid held high
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_carry", 64'(carry_flag), 64'(0));
        chk("rst_alu_a", 64'(alu_a), 64'(0));
        chk("rst_alu_ci", 64'(alu_ci), 64'(0));
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        idle(3);
        chk("post_rst_no_output", 64'(dut_log.size()), 64'(0));

        // Single op
        base = dut_log.size();
        send(32'd1, 32'd2, 5'd1, 1'b0);
        @(negedge clk); in_valid = 1'b0; #2;
        chk("single_alu_a", 64'(alu_a), 64'(1));
        chk("single_alu_b", 64'(alu_b), 64'(2));
        chk("single_alu_f", 64'(alu_f), 64'(1));
        chk("single_not_yet", 64'(out_valid), 64'(0));
        @(negedge clk); #2;
        chk("single_valid", 64'(out_valid), 64'(1));
        chk("single_s", 64'(out_s), 64'(3));
        chk("single_co", 64'(out_co), 64'(0));
        @(negedge clk); #2;
        chk("single_one_cycle", 64'(out_valid), 64'(0));

        // 64-bit add chained over two 32-bit ops
        base = dut_log.size();
        send(32'hFFFF_FFFF, 32'd1, 5'd2, 1'b0);
        send(32'd0, 32'd0, 5'd2, 1'b1);
        idle(4);
        chk("chain_count", 64'(dut_log.size()), 64'(base + 2));
        if (dut_log.size() >= base + 2) begin
            chk("chain_lo", 64'(dut_log[base]), 64'({1'b1, 32'h0000_0000}));
            chk("chain_hi", 64'(dut_log[base+1]), 64'({1'b0, 32'h0000_0001}));
        end
        chk("chain_carry_end", 64'(carry_flag), 64'(0));

        // Backpressure: two packets buffered, third stalls
        base = dut_log.size();
        @(negedge clk); out_ready = 1'b0;
        send(32'd1, 32'd1, 5'd4, 1'b0);
        send(32'd2, 32'd2, 5'd4, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'd3; in_b = 32'd3; in_f = 5'd4; in_use_carry = 1'b0;
        #1;
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        chk("bp_hold_valid", 64'(out_valid), 64'(1));
        chk("bp_hold_s", 64'(out_s), 64'(2));
        out_ready = 1'b1;
        @(posedge clk);
        idle(5);
        chk("bp_count", 64'(dut_log.size()), 64'(base + 3));
        if (dut_log.size() >= base + 3) begin
            chk("bp_r0", 64'(dut_log[base]), 64'(2));
            chk("bp_r1", 64'(dut_log[base+1]), 64'(4));
            chk("bp_r2", 64'(dut_log[base+2]), 64'(6));
        end

        // clr_carry collides with an advancing op that carries out
        send(32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        idle(1);
        send(32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1);
        @(negedge clk); in_valid = 1'b0; clr_carry = 1'b1;
        @(negedge clk); clr_carry = 1'b0; #2;
        chk("clr_carry_wins", 64'(carry_flag), 64'(0));
        chk("clr_out_co", 64'(out_co), 64'(1));
        chk("clr_out_s", 64'(out_s), 64'(1));
        idle(2);

        // Reset with one packet in O and one in R
        @(negedge clk); out_ready = 1'b0;
        send(32'hFFFF_FFFF, 32'd1, 5'd5, 1'b0);
        send(32'd6, 32'd6, 5'd5, 1'b0);
        @(negedge clk); in_valid = 1'b0; #2;
        chk("mid_pre_carry", 64'(carry_flag), 64'(1));
        chk("mid_pre_valid", 64'(out_valid), 64'(1));
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; #2;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_carry", 64'(carry_flag), 64'(0));
        base = dut_log.size();
        @(negedge clk); out_ready = 1'b1;
        idle(4);
        chk("mid_rst_nothing_out", 64'(dut_log.size()), 64'(base));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage wrapper directly upstream of the combinational `alu`.
- Accepts operand/function packets over a valid/ready handshake and registers them onto the ALU input ports.
- Captures the ALU sum and carry into a result register with its own valid/ready handshake.
- Holds an architectural carry flag so that multi-word chained operations can feed `ci` automatically.

Parameters:
- WIDTH, default `ALU_WIDTH (32), operand/result width; must match the attached alu.
- FUNC_WIDTH, default `ALU_FUNC_WIDTH (5), function-code width; passed through unmodified.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream packet valid
- in_ready  out  1  stage can accept packet
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_f  in  FUNC_WIDTH  ALU function code
- in_use_carry  in  1  1: ci = carry flag; 0: ci = 0
- clr_carry  in  1  synchronous clear of carry flag
- alu_a  out  WIDTH  to alu.a
- alu_b  out  WIDTH  to alu.b
- alu_ci  out  1  to alu.ci
- alu_f  out  FUNC_WIDTH  to alu.f
- alu_s  in  WIDTH  from alu.s
- alu_co  in  1  from alu.co
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_s  out  WIDTH  registered result
- out_co  out  1  registered carry-out
- carry_flag  out  1  current architectural carry

Behaviour:
- Clock and reset: single clock domain; reset is synchronous, active-low on rst_n.
- Reset (rst_n=0 at a rising edge): all of the following clear to 0.
  - o_valid, out_valid, carry_flag.
  - Operand registers, so alu_a/alu_b/alu_f = 0 and alu_ci = 0.
  - out_s, out_co.
  - Reset mid-operation discards any in-flight packets; no partial output.
- Stage O (operand register) holds a, b, f, use_carry and o_valid.
  - alu_a/alu_b/alu_f are driven directly from the O registers.
  - alu_ci = o_use_carry & carry_flag (combinational).
- Stage R (result register) holds out_s, out_co and out_valid.
- Advance condition: o_adv = o_valid & (~out_valid | out_ready).
- in_ready = ~o_valid | o_adv (combinational; full throughput with a single O entry).
- Accept: when in_valid & in_ready, O loads the in_* fields and o_valid <= 1.
  - Otherwise, if o_adv, o_valid <= 0.
  - Otherwise O holds.
- Capture: on o_adv, out_s <= alu_s, out_co <= alu_co, out_valid <= 1.
  - Else if out_ready, out_valid <= 0.
  - Otherwise R holds; out_s/out_co are stable while out_valid & ~out_ready.
- Carry flag:
  - On o_adv, carry_flag <= alu_co.
  - clr_carry has priority over the o_adv update in the same cycle.
  - Not changed by anything else.
- Chaining: because carry_flag updates on the same edge the next packet moves into O, back-to-back chained ops see the previous op's carry with no bubble.
- Latency and throughput:
  - Accept edge → out_valid high after 2 rising edges (input edge, then capture edge).
  - 1 packet/cycle sustained when out_ready = 1.
- Backpressure: with out_ready = 0, at most 2 packets are buffered (O + R); in_ready drops once both are full.
  - No data is dropped or duplicated.
  - A packet sitting in O keeps its alu_* drive stable.
- Function codes: not decoded; alu_f is forwarded and every code is treated alike.

Test Plan:
- The bench drives a behavioural alu stub: s = a + b + ci, co = carry out of the WIDTH-bit add.
- Reset: rst_n=0 for 2 cycles with in_valid=1 → in_ready=1, out_valid=0, carry_flag=0, all alu_* = 0; nothing captured after release until a new accept.
- Single op: a=1, b=2, f=1, use_carry=0, out_ready=1 → alu_a=1, alu_b=2, alu_f=1 one cycle after accept; out_s=3, out_co=0, out_valid for exactly 1 cycle, 2 cycles after accept.
- 64-bit add chained over WIDTH=32: {a=FFFFFFFF, b=1, uc=0} then {a=0, b=0, uc=1} on consecutive cycles → outputs 00000000/co=1, then 00000001/co=0; carry_flag ends at 0.
- Backpressure: out_ready=0 while streaming 3 packets (1+1, 2+2, 3+3):
  - in_ready falls after 2 accepts; out_s holds 2.
  - When out_ready=1, results 2, 4, 6 appear in order, with none lost.
- clr_carry collision: carry_flag=1; clr_carry=1 in the same cycle an op with co=1 advances → carry_flag=0 next cycle; out_co=1.
- Mid-operation reset: one packet in O and one in R, out_ready=0; assert rst_n=0 for one cycle → out_valid=0, in_ready=1, carry_flag=0 on the next cycle.
